// File: rtl/lcd_pixel_pipe.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pixel_pipe
// Description : Maps 2-bit raw LCD pixels through a selectable 8-bit palette.
//               The mapped shade and its coordinates go into a
//               first-word-fall-through FIFO. The FIFO either backpressures
//               when full or drops the pixel and sets a sticky flag.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_pixel_pipe #(
    parameter int NUM_PAL   = 3,
    parameter int PAL_SEL_W = 2,
    parameter int DEPTH     = 8,
    parameter int BLOCKING  = 1
) (
    input  logic                           clock,
    input  logic                           nreset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [1:0]                     in_data,
    input  logic [PAL_SEL_W-1:0]           in_pal,
    input  logic [7:0]                     in_x,
    input  logic [7:0]                     in_y,
    input  logic                           pal_wr_en,
    input  logic [PAL_SEL_W-1:0]           pal_wr_idx,
    input  logic [7:0]                     pal_wr_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [1:0]                     out_color,
    output logic [7:0]                     out_x,
    output logic [7:0]                     out_y,
    output logic                           out_sof,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [7:0]    PAL_RESET  = 8'hE4;

    logic [7:0]    pal [NUM_PAL];
    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [7:0]    sel_pal;
    logic [1:0]    shade;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;

    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);
    assign pop   = out_ready && !empty;

    // Select the palette for the incoming pixel; unknown indices read as all ones
    always_comb begin
        sel_pal = 8'hFF;
        for (int i = 0; i < NUM_PAL; i++) begin
            if (in_pal == PAL_SEL_W'(i)) begin
                sel_pal = pal[i];
            end
        end
    end

    // Pick the 2-bit field of the palette addressed by the raw pixel value
    always_comb begin
        shade = sel_pal[1:0];
        case (in_data)
            2'd0:    shade = sel_pal[1:0];
            2'd1:    shade = sel_pal[3:2];
            2'd2:    shade = sel_pal[5:4];
            default: shade = sel_pal[7:6];
        endcase
    end

    // Full handling: backpressure, or accept always and drop when no room
    generate
        if (BLOCKING != 0) begin : g_blocking
            assign in_ready = !full;
            assign push     = in_valid && !full;
            assign drop     = 1'b0;
        end else begin : g_dropping
            assign in_ready = 1'b1;
            assign push     = in_valid && (!full || pop);
            assign drop     = in_valid && full && !pop;
        end
    endgenerate

    // Pointers, occupancy and sticky overflow; flush behaves like a FIFO-only reset
    always_ff @(posedge clock) begin
        if (!nreset || flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage array; holds only the mapped shade and coordinates
    always_ff @(posedge clock) begin
        if (nreset && !flush && push) begin
            mem[wr_ptr] <= {shade, in_x, in_y};
        end
    end

    // Palette registers; the new value is seen by pixels from the next edge on
    always_ff @(posedge clock) begin
        if (!nreset) begin
            for (int i = 0; i < NUM_PAL; i++) begin
                pal[i] <= PAL_RESET;
            end
        end else if (pal_wr_en) begin
            for (int i = 0; i < NUM_PAL; i++) begin
                if (pal_wr_idx == PAL_SEL_W'(i)) begin
                    pal[i] <= pal_wr_data;
                end
            end
        end
    end

    assign {out_color, out_x, out_y} = mem[rd_ptr];
    assign out_valid = !empty;
    assign out_sof   = out_valid && (out_x == 8'd0) && (out_y == 8'd0);

endmodule
`default_nettype wire

// File: tb/tb_lcd_pixel_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_pixel_pipe
// Description : Drives a backpressuring and a dropping instance with the same
//               stimulus and compares both against queue-based reference models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_pixel_pipe;

    localparam int NUM_PAL   = 3;
    localparam int PAL_SEL_W = 2;
    localparam int DEPTH     = 8;

    typedef logic [17:0] ent_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                 nreset, flush, in_valid, out_ready, pal_wr_en;
    logic [1:0]           in_data;
    logic [PAL_SEL_W-1:0] in_pal, pal_wr_idx;
    logic [7:0]           in_x, in_y, pal_wr_data;

    // index 0: blocking instance, index 1: dropping instance
    logic [1:0] ir, ov, sof, of;
    logic [1:0] col [2];
    logic [7:0] ox  [2];
    logic [7:0] oy  [2];
    logic [3:0] lv  [2];

    lcd_pixel_pipe #(.NUM_PAL(NUM_PAL), .PAL_SEL_W(PAL_SEL_W), .DEPTH(DEPTH), .BLOCKING(1)) dut_blk (
        .clock(clock), .nreset(nreset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .in_pal(in_pal), .in_x(in_x), .in_y(in_y), .pal_wr_en(pal_wr_en),
        .pal_wr_idx(pal_wr_idx), .pal_wr_data(pal_wr_data), .out_valid(ov[0]), .out_ready(out_ready),
        .out_color(col[0]), .out_x(ox[0]), .out_y(oy[0]), .out_sof(sof[0]), .level(lv[0]),
        .overflow(of[0])
    );

    lcd_pixel_pipe #(.NUM_PAL(NUM_PAL), .PAL_SEL_W(PAL_SEL_W), .DEPTH(DEPTH), .BLOCKING(0)) dut_drp (
        .clock(clock), .nreset(nreset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .in_pal(in_pal), .in_x(in_x), .in_y(in_y), .pal_wr_en(pal_wr_en),
        .pal_wr_idx(pal_wr_idx), .pal_wr_data(pal_wr_data), .out_valid(ov[1]), .out_ready(out_ready),
        .out_color(col[1]), .out_x(ox[1]), .out_y(oy[1]), .out_sof(sof[1]), .level(lv[1]),
        .overflow(of[1])
    );

    // Reference model state
    ent_t       q [2][$];
    bit         ovf [2];
    logic [7:0] pal [NUM_PAL];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] shade_of(input logic [1:0] d, input int p);
        logic [7:0] v;
        v = 8'hFF;
        if (p < NUM_PAL) v = pal[p];
        return v[int'(d)*2 +: 2];
    endfunction

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            string nm;
            ent_t  h;
            nm = (k == 0) ? "blk" : "drp";
            check({nm, "_level"}, 32'(lv[k]), 32'(q[k].size()));
            check({nm, "_valid"}, 32'(ov[k]), 32'(q[k].size() != 0));
            check({nm, "_ready"}, 32'(ir[k]), (k == 0) ? 32'(q[k].size() != DEPTH) : 32'd1);
            check({nm, "_ovf"},   32'(of[k]), 32'(ovf[k]));
            if (q[k].size() != 0) begin
                h = q[k][0];
                check({nm, "_color"}, 32'(col[k]), 32'(h[17:16]));
                check({nm, "_x"},     32'(ox[k]),  32'(h[15:8]));
                check({nm, "_y"},     32'(oy[k]),  32'(h[7:0]));
                check({nm, "_sof"},   32'(sof[k]), 32'(h[15:0] == 16'd0));
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_edge();
        ent_t e;
        e = {shade_of(in_data, int'(in_pal)), in_x, in_y};
        for (int k = 0; k < 2; k++) begin
            if (!nreset || flush) begin
                q[k].delete();
                ovf[k] = 1'b0;
            end else begin
                bit full_n, pop_n, acc_n;
                full_n = (q[k].size() == DEPTH);
                pop_n  = out_ready && (q[k].size() != 0);
                acc_n  = in_valid && ((k == 0) ? !full_n : (!full_n || pop_n));
                if (k == 1 && in_valid && full_n && !pop_n) ovf[k] = 1'b1;
                if (pop_n) void'(q[k].pop_front());
                if (acc_n) q[k].push_back(e);
            end
        end
        if (!nreset) begin
            for (int i = 0; i < NUM_PAL; i++) pal[i] = 8'hE4;
        end else if (pal_wr_en && int'(pal_wr_idx) < NUM_PAL) begin
            pal[int'(pal_wr_idx)] = pal_wr_data;
        end
    endtask

    task automatic step();
        #1;
        check_all();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic push_px(input logic [1:0] d, input logic [1:0] p, input logic [7:0] x, input logic [7:0] y);
        in_valid = 1'b1; in_data = d; in_pal = p; in_x = x; in_y = y;
        step();
    endtask

    initial begin
        nreset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pal_wr_en = 1'b0;
        in_data = '0; in_pal = '0; in_x = '0; in_y = '0; pal_wr_idx = '0; pal_wr_data = '0;
        model_edge();
        @(posedge clock);
        #1;
        step();
        nreset = 1'b1;
        check("rst_level", 32'(lv[0]), 32'd0);
        check("rst_valid", 32'(ov[1]), 32'd0);
        check("rst_ready_blk", 32'(ir[0]), 32'd1);
        check("rst_ready_drp", 32'(ir[1]), 32'd1);

        // identity palette, one-cycle latency
        out_ready = 1'b1;
        for (int d = 0; d < 4; d++) begin
            push_px(2'(d), 2'd0, 8'(d + 1), 8'd5);
            if (d == 0) begin
                check("lat_valid", 32'(ov[0]), 32'd1);
                check("lat_color", 32'(col[0]), 32'd0);
            end
        end
        in_valid = 1'b0;
        step();
        step();

        // fill to full with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push_px(2'(i % 4), 2'd0, 8'(i), 8'd1);
            if (i == 7) check("full_ready_blk", 32'(ir[0]), 32'd0);
        end
        in_valid = 1'b0;
        check("full_level_blk", 32'(lv[0]), 32'd8);
        check("full_level_drp", 32'(lv[1]), 32'd8);
        check("full_ovf_blk", 32'(of[0]), 32'd0);
        check("full_ovf_drp", 32'(of[1]), 32'd1);
        check("full_head_drp", 32'(ox[1]), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_level", 32'(lv[1]), 32'd0);
        check("flush_ovf", 32'(of[1]), 32'd0);

        // palette write at the same edge as an accept
        out_ready = 1'b0;
        pal_wr_en = 1'b1; pal_wr_idx = 2'd1; pal_wr_data = 8'h1B;
        push_px(2'd0, 2'd1, 8'd10, 8'd10);
        pal_wr_en = 1'b0;
        push_px(2'd0, 2'd1, 8'd11, 8'd10);
        in_valid = 1'b0;
        check("pal_old", 32'(col[0]), 32'd0);
        out_ready = 1'b1;
        step();
        check("pal_new", 32'(col[0]), 32'd3);
        step();

        // out-of-range palette and start-of-frame
        out_ready = 1'b0;
        push_px(2'd0, 2'd3, 8'd0, 8'd0);
        push_px(2'd0, 2'd0, 8'd1, 8'd0);
        in_valid = 1'b0;
        check("badpal_color", 32'(col[0]), 32'd3);
        check("sof_set", 32'(sof[0]), 32'd1);
        out_ready = 1'b1;
        step();
        check("sof_clear", 32'(sof[0]), 32'd0);
        step();

        // reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_px(2'd2, 2'd0, 8'(i + 3), 8'd7);
        in_valid = 1'b0;
        check("pre_rst_level", 32'(lv[0]), 32'd5);
        nreset = 1'b0;
        step();
        nreset = 1'b1;
        check("mid_rst_level", 32'(lv[0]), 32'd0);
        check("mid_rst_valid", 32'(ov[1]), 32'd0);
        push_px(2'd1, 2'd1, 8'd2, 8'd3);
        in_valid = 1'b0;
        check("mid_rst_pal", 32'(col[0]), 32'd1);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            int rphase;
            rphase      = c / 250;
            nreset      = ($urandom_range(0, 149) != 0);
            flush       = ($urandom_range(0, 79) == 0);
            in_valid    = ($urandom_range(0, 9) < 7);
            out_ready   = ($urandom_range(0, 9) < ((rphase % 2 == 0) ? 3 : 8));
            in_data     = 2'($urandom);
            in_pal      = 2'($urandom);
            in_x        = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 3));
            in_y        = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            pal_wr_en   = ($urandom_range(0, 7) == 0);
            pal_wr_idx  = 2'($urandom);
            pal_wr_data = 8'($urandom);
            step();
        end
        nreset = 1'b1; flush = 1'b0; in_valid = 1'b0; pal_wr_en = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
